alu_cmd_queue: RTL
==================

ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, command queue entries (power of two, 2..16).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port flush  input  1  synchronous clear of queue and result stage.
REQ-005 SHALL provide port in_valid  input  1  command offered.
REQ-006 SHALL provide port in_ready  output  1  queue can accept a command.
REQ-007 SHALL provide ports in_a, in_b  input  8 each, and in_opcode  input  3: command operands and opcode.
REQ-008 SHALL provide ports alu_a, alu_b  output  8 each, and alu_opcode  output  3: drive the downstream 8-bit ALU.
REQ-009 SHALL provide port alu_out  input  8  combinational ALU result for the current alu_* operands.
REQ-010 SHALL provide port res_valid  output  1  result stage holds a result.
REQ-011 SHALL provide port res_ready  input  1  consumer accepts result.
REQ-012 SHALL provide ports res_data  output  8, and res_opcode  output  3: result and the opcode that produced it.
REQ-013 SHALL provide port count  output  $clog2(DEPTH)+1  current queue occupancy, 0..DEPTH.

Function
REQ-014 SHALL push {in_opcode,in_a,in_b} on an edge where in_valid && in_ready; in_ready = (count < DEPTH), from registered state only.
REQ-015 SHALL assert in_ready low when count == DEPTH, even if a pop occurs the same cycle; no full-queue pass-through.
REQ-016 SHALL drive alu_a/alu_b/alu_opcode from the queue head entry when count > 0, and all zeros when count == 0.
REQ-017 SHALL define pop = (count > 0) && (!res_valid || res_ready).
REQ-018 On pop, SHALL register alu_out into res_data, alu_opcode into res_opcode, and set res_valid = 1.
REQ-019 SHALL clear res_valid on an edge with res_valid && res_ready && !pop; res_data/res_opcode hold their last value.
REQ-020 SHALL hold res_data, res_opcode and res_valid stable while res_valid && !res_ready.
REQ-021 SHALL give minimum latency one cycle: command pushed at edge k into an empty queue with free result stage appears on res_data after edge k+1.
REQ-022 SHALL sustain one command per cycle throughput when res_ready is held high.
REQ-023 SHALL apply push and pop in the same edge: count unchanged, FIFO order preserved.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; count is the authoritative full/empty indicator.
REQ-025 SHALL, on flush high at an edge, set count = 0, pointers = 0, res_valid = 0, and ignore that cycle's push and pop.

Reset
REQ-026 SHALL on rst_n low immediately set count = 0, pointers = 0, res_valid = 0, res_data = 0, res_opcode = 0; in_ready = 1 after reset; storage contents need not reset.
REQ-027 SHALL discard queued commands and any pending result when reset asserts mid-operation; no result is produced for them.

Configuration
REQ-028 With macro ALU_CMD_QUEUE_FLAGS_EN defined, SHALL add outputs res_zero (1) and res_neg (1), registered with res_data on pop: res_zero = (alu_out == 0), res_neg = alu_out[7]; both reset to 0 and held with res_data.
REQ-029 Without ALU_CMD_QUEUE_FLAGS_EN, SHALL omit res_zero and res_neg ports and logic; all other behaviour identical.

Verification
REQ-030 Single op: push opcode 000, a=8'h0F, b=8'h01, res_ready=1 -> res_valid high one edge later, res_data=8'h10, res_opcode=000.
REQ-031 Fill: res_ready=0, push 5 commands with DEPTH=4 -> first enters result stage, next 4 fill queue, count=4, in_ready=0; 6th offered command not accepted; res_data stable.
REQ-032 Back-to-back: res_ready=1, push 8 consecutive commands (opcodes 000..111, a=8'h80, b=8'h01) -> 8 results in order on consecutive cycles, including 8'h81, 8'h82, 8'h7F, 8'h7E, 8'h00, 8'h81, 8'h00, 8'h40.
REQ-033 Simultaneous push/pop at count=2 -> count stays 2, results in push order.
REQ-034 Flush with count=3 and res_valid=1 -> next cycle count=0, res_valid=0, in_ready=1; a command pushed in the flush cycle never produces a result.
REQ-035 Assert rst_n low mid-stream -> outputs reach reset values without a clock edge; with ALU_CMD_QUEUE_FLAGS_EN, opcode 010 a=b=8'h01 -> res_zero=1, res_neg=0.

Source files
------------

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: command FIFO in front of an external combinational 8-bit ALU.
// The head entry drives the ALU. Its result is captured into a one-deep
// valid/ready result stage.
// Optional macro ALU_CMD_QUEUE_FLAGS_EN adds registered res_zero/res_neg flags.
module alu_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_a,
  input  logic [7:0]               in_b,
  input  logic [2:0]               in_opcode,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  output logic [2:0]               alu_opcode,
  input  logic [7:0]               alu_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [7:0]               res_data,
  output logic [2:0]               res_opcode,
`ifdef ALU_CMD_QUEUE_FLAGS_EN
  output logic                     res_zero,
  output logic                     res_neg,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, nonempty;

  // Handshake decode. Every term comes from registered state, so a full
  // queue never accepts a command, even when it pops on the same edge.
  // Flush suppresses both push and pop for its cycle.
  always_comb begin
    nonempty = (count != '0);
    in_ready = (count < FULL);
    push     = in_valid && in_ready && !flush;
    pop      = nonempty && (!res_valid || res_ready) && !flush;
  end

  // The head entry feeds the ALU. The operands are forced to zero when the
  // queue is empty, so the ALU inputs do not show stale storage.
  always_comb begin
    head       = mem[rd_ptr];
    alu_a      = nonempty ? head.a  : 8'h00;
    alu_b      = nonempty ? head.b  : 8'h00;
    alu_opcode = nonempty ? head.op : 3'b000;
  end

  // Storage array. It has no reset, and count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: in_opcode, a: in_a, b: in_b};
  end

  // Pointers wrap naturally at DEPTH (power of two). Count is the only
  // authority for full/empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Result stage. A pop loads the stage. A consumed result with no new pop
  // empties it. The data fields keep their last value when not loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid  <= 1'b0;
      res_data   <= 8'h00;
      res_opcode <= 3'b000;
`ifdef ALU_CMD_QUEUE_FLAGS_EN
      res_zero   <= 1'b0;
      res_neg    <= 1'b0;
`endif
    end else if (flush) begin
      res_valid  <= 1'b0;
    end else if (pop) begin
      res_valid  <= 1'b1;
      res_data   <= alu_out;
      res_opcode <= alu_opcode;
`ifdef ALU_CMD_QUEUE_FLAGS_EN
      res_zero   <= (alu_out == 8'h00);
      res_neg    <= alu_out[7];
`endif
    end else if (res_ready) begin
      res_valid  <= 1'b0;
    end
  end

endmodule
